fp_addsub_pipe: RTL and testbench

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

---
 rtl/fp_pkg.sv | 32 +++
 rtl/fp_lzc.sv | 20 ++
 rtl/fp_addsub_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types, exception bit positions and special-value constants for the FP add/sub pipe
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    // Operand after unpacking: sig carries the hidden bit above the stored fraction.
    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W:0]   sig;
    } fp_unpacked_t;

    localparam int EXC_INVALID   = 2;
    localparam int EXC_OVERFLOW  = 1;
    localparam int EXC_UNDERFLOW = 0;

    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

    function automatic logic [63:0] fp_inf(input int exp_w, input int man_w, input logic sign);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'(sign) << (exp_w + man_w));
        return v;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - leading-zero counter; an all-zero input returns WIDTH
module fp_lzc
    import fp_pkg::*;
#(
    parameter int WIDTH = 27,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_count
);

    // Scanning upward lets the highest set bit make the final assignment.
    always_comb begin
        o_count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) o_count = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// rtl/fp_addsub_pipe.sv - 3-stage FP adder/subtractor; FP_ADDSUB_ROUND_EN selects RNE, otherwise truncation
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   r,
    output logic [2:0]             exc
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 1;
    localparam int XW    = SIG_W + 3;
    localparam int LZ_W  = $clog2(XW + 1);
    localparam int EW2   = EXP_W + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]     QNAN     = W'(fp_qnan(EXP_W, MAN_W));

    logic w_advance;
    assign w_advance = !out_valid | out_ready;
    assign in_ready  = w_advance;

    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic [SIG_W-1:0] w_ma, w_mb;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_nan, w_inf, w_a_ge_b;

    assign w_sa     = a[W-1];
    assign w_sb     = b[W-1] ^ op;
    assign w_ea     = a[W-2:MAN_W];
    assign w_eb     = b[W-2:MAN_W];
    assign w_fa     = a[MAN_W-1:0];
    assign w_fb     = b[MAN_W-1:0];
    assign w_a_nan  = (w_ea == EXP_ONES) && (w_fa != '0);
    assign w_b_nan  = (w_eb == EXP_ONES) && (w_fb != '0);
    assign w_a_inf  = (w_ea == EXP_ONES) && (w_fa == '0);
    assign w_b_inf  = (w_eb == EXP_ONES) && (w_fb == '0);
    assign w_nan    = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa != w_sb));
    assign w_inf    = (w_a_inf | w_b_inf) & !w_nan;
    // Subnormals flush to zero here, so they never reach the datapath.
    assign w_ma     = (w_ea == '0) ? '0 : {1'b1, w_fa};
    assign w_mb     = (w_eb == '0) ? '0 : {1'b1, w_fb};
    assign w_a_ge_b = {w_ea, w_ma} >= {w_eb, w_mb};

    logic             w_sign_l;
    logic [EXP_W-1:0] w_exp_l, w_exp_s, w_shift;
    logic [SIG_W-1:0] w_sig_l, w_sig_s;
    logic [XW-1:0]    w_ext_s, w_aligned;

    always_comb begin
        w_sign_l = w_a_ge_b ? w_sa : w_sb;
        w_exp_l  = w_a_ge_b ? w_ea : w_eb;
        w_exp_s  = w_a_ge_b ? w_eb : w_ea;
        w_sig_l  = w_a_ge_b ? w_ma : w_mb;
        w_sig_s  = w_a_ge_b ? w_mb : w_ma;
        w_shift  = w_exp_l - w_exp_s;
        w_ext_s  = {w_sig_s, 3'b000};
        if (32'(w_shift) >= XW - 1)
            w_aligned = {{(XW-1){1'b0}}, |w_sig_s};
        else
            w_aligned = (w_ext_s >> w_shift)
                      | {{(XW-1){1'b0}}, |(w_ext_s & ~({XW{1'b1}} << w_shift))};
    end

    logic             r_s1_valid, r_s1_nan, r_s1_inf, r_s1_sign, r_s1_sub;
    logic [EXP_W-1:0] r_s1_exp;
    logic [XW-1:0]    r_s1_sig_l, r_s1_sig_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_nan   <= 1'b0;
            r_s1_inf   <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_sub   <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_sig_l <= '0;
            r_s1_sig_s <= '0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            r_s1_nan   <= w_nan;
            r_s1_inf   <= w_inf;
            r_s1_sign  <= w_inf ? (w_a_inf ? w_sa : w_sb) : w_sign_l;
            r_s1_sub   <= w_sa ^ w_sb;
            r_s1_exp   <= w_exp_l;
            r_s1_sig_l <= {w_sig_l, 3'b000};
            r_s1_sig_s <= w_aligned;
        end
    end

    logic             r_s2_valid, r_s2_nan, r_s2_inf, r_s2_sign, r_s2_sub;
    logic [EXP_W-1:0] r_s2_exp;
    logic [XW:0]      r_s2_sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_valid <= 1'b0;
            r_s2_nan   <= 1'b0;
            r_s2_inf   <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_sub   <= 1'b0;
            r_s2_exp   <= '0;
            r_s2_sum   <= '0;
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            r_s2_nan   <= r_s1_nan;
            r_s2_inf   <= r_s1_inf;
            r_s2_sign  <= r_s1_sign;
            r_s2_sub   <= r_s1_sub;
            r_s2_exp   <= r_s1_exp;
            r_s2_sum   <= r_s1_sub ? ({1'b0, r_s1_sig_l} - {1'b0, r_s1_sig_s})
                                   : ({1'b0, r_s1_sig_l} + {1'b0, r_s1_sig_s});
        end
    end

    logic [LZ_W-1:0]  w_lz;
    logic [XW-1:0]    w_norm;
    logic [EW2-1:0]   w_exp_n, w_exp_f;
    logic [SIG_W:0]   w_mant;
    logic [MAN_W-1:0] w_frac;
    logic [W-1:0]     w_res;
    logic [2:0]       w_exc;

    fp_lzc #(
        .WIDTH (XW),
        .CNT_W (LZ_W)
    ) u_lzc (
        .i_data  (r_s2_sum[XW-1:0]),
        .o_count (w_lz)
    );

    always_comb begin
        if (r_s2_sum[XW]) begin
            w_norm  = {r_s2_sum[XW:2], |r_s2_sum[1:0]};
            w_exp_n = EW2'(r_s2_exp) + EW2'(1);
        end else begin
            w_norm  = r_s2_sum[XW-1:0] << w_lz;
            w_exp_n = EW2'(r_s2_exp) - EW2'(w_lz);
        end
    end

`ifdef FP_ADDSUB_ROUND_EN
    logic w_inc;
    assign w_inc  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    assign w_mant = {1'b0, w_norm[XW-1:3]} + (SIG_W+1)'(w_inc);
`else
    assign w_mant = (SIG_W+1)'({1'b0, w_norm} >> 3);
`endif

    // Exponent is kept two bits wider so a wrapped (negative) value flags underflow.
    always_comb begin
        w_exp_f = w_exp_n + EW2'(w_mant[SIG_W]);
        w_frac  = w_mant[SIG_W] ? w_mant[MAN_W:1] : w_mant[MAN_W-1:0];
        w_res   = {r_s2_sign, w_exp_f[EXP_W-1:0], w_frac};
        w_exc   = '0;
        if (r_s2_nan) begin
            w_res              = QNAN;
            w_exc[EXC_INVALID] = 1'b1;
        end else if (r_s2_inf) begin
            w_res = W'(fp_inf(EXP_W, MAN_W, r_s2_sign));
        end else if (r_s2_sum == '0) begin
            w_res = {r_s2_sign & ~r_s2_sub, {(W-1){1'b0}}};
        end else if (w_exp_f[EW2-1] || (w_exp_f == '0)) begin
            w_res                = {r_s2_sign, {(W-1){1'b0}}};
            w_exc[EXC_UNDERFLOW] = 1'b1;
        end else if (w_exp_f >= EW2'(EXP_ONES)) begin
            w_res               = W'(fp_inf(EXP_W, MAN_W, r_s2_sign));
            w_exc[EXC_OVERFLOW] = 1'b1;
        end
    end

    logic         r_out_valid;
    logic [W-1:0] r_r;
    logic [2:0]   r_exc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_r         <= '0;
            r_exc       <= '0;
        end else if (w_advance) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_r   <= w_res;
                r_exc <= w_exc;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign r         = r_r;
    assign exc       = r_exc;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb/tb_fp_addsub_pipe.sv - scoreboard bench for fp_addsub_pipe (single precision)
module tb_fp_addsub_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] r;
    logic [2:0]   exc;

    int n_pass  = 0;
    int n_total = 0;
    logic [W+2:0] exp_q[$];

`ifdef FP_ADDSUB_ROUND_EN
    localparam logic [W-1:0] RND_UP = 32'h3F800001;
`else
    localparam logic [W-1:0] RND_UP = 32'h3F800000;
`endif

    always #5 clk = ~clk;

    fp_addsub_pipe #(
        .EXP_W (8),
        .MAN_W (23)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .exc       (exc)
    );

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic top,
                        input logic [W+2:0] expv);
        int guard;
        guard = 0;
        a = ta; b = tb_v; op = top; in_valid = 1'b1;
        #1;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        exp_q.push_back(expv);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if (r !== '0) $display("FAIL reset_r: got %h expected 00000000", r); else n_pass++;
        n_total++; if (exc !== 3'b000) $display("FAIL reset_exc: got %b expected 000", exc); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_latency();
        logic [W+2:0] got, expv;
        send(32'h3F800000, 32'h40000000, 1'b0, {3'b000, 32'h40400000});
        n_total++; if (out_valid !== 1'b0) $display("FAIL latency_c1: got %b expected 0", out_valid); else n_pass++;
        @(negedge clk);
        n_total++; if (out_valid !== 1'b0) $display("FAIL latency_c2: got %b expected 0", out_valid); else n_pass++;
        @(negedge clk);
        n_total++; if (out_valid !== 1'b1) $display("FAIL latency_c3: got %b expected 1", out_valid); else n_pass++;
        got = {exc, r};
        expv = exp_q.pop_front();
        n_total++; if (got !== expv) $display("FAIL latency_result: got %h expected %h", got, expv); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_arith_cases(input string name, input logic [W-1:0] ta [], input logic [W-1:0] tbv [],
                                    input logic top [], input logic [W+2:0] te []);
        logic [W+2:0] got, expv;
        for (int i = 0; i < ta.size(); i++) begin
            send(ta[i], tbv[i], top[i], te[i]);
            for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
                @(negedge clk);
                if (out_valid) begin
                    got = {exc, r};
                    expv = exp_q.pop_front();
                    n_total++;
                    if (got !== expv) $display("FAIL %s[%0d]: got %h expected %h", name, i, got, expv);
                    else n_pass++;
                end
            end
            n_total++;
            if (exp_q.size() != 0) begin
                $display("FAIL %s_timeout[%0d]: got %0d pending expected 0", name, i, exp_q.size());
                exp_q.delete();
            end else n_pass++;
        end
    endtask

    task automatic test_cancel();
        test_arith_cases("cancel",
            '{32'h3F800000, 32'h80000000, 32'h00000001, 32'h80000000},
            '{32'h3F800000, 32'h00000000, 32'h00000000, 32'h00000000},
            '{1'b1, 1'b1, 1'b0, 1'b0},
            '{{3'b000, 32'h00000000}, {3'b000, 32'h80000000},
              {3'b000, 32'h00000000}, {3'b000, 32'h00000000}});
    endtask

    task automatic test_exceptions();
        test_arith_cases("exceptions",
            '{32'h7F7FFFFF, 32'h7F800000, 32'h7F800000, 32'h7F800001},
            '{32'h7F7FFFFF, 32'h7F800000, 32'h3F800000, 32'h00000000},
            '{1'b0, 1'b1, 1'b0, 1'b0},
            '{{3'b010, 32'h7F800000}, {3'b100, 32'h7FC00000},
              {3'b000, 32'h7F800000}, {3'b100, 32'h7FC00000}});
    endtask

    task automatic test_rounding();
        test_arith_cases("rounding",
            '{32'h3F800000, 32'h3F800000},
            '{32'h33800000, 32'h33800001},
            '{1'b0, 1'b0},
            '{{3'b000, 32'h3F800000}, {3'b000, RND_UP}});
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] sa [6] = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'hC0A00000, 32'h3F000000, 32'h41200000};
        logic [W-1:0] sb [6] = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h3F000000, 32'h41200000};
        logic         so [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] se [6] = '{32'h40400000, 32'h40000000, 32'h40800000, 32'hC0000000, 32'h3F800000, 32'h00000000};
        int got_n;
        int extra;
        logic [W+2:0] expv;
        got_n = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(sa[i], sb[i], so[i], {3'b000, se[i]});
            end
            begin
                for (int cyc = 0; cyc < 80 && got_n < 6; cyc++) begin
                    @(negedge clk);
                    out_ready = !(cyc >= 4 && cyc < 8);
                    if (cyc >= 4 && cyc < 8) begin
                        n_total++;
                        if (out_valid !== 1'b1 || exp_q.size() == 0 || {exc, r} !== exp_q[0])
                            $display("FAIL b2b_stall_hold[%0d]: got v=%b %h expected v=1 %h", cyc, out_valid, {exc, r},
                                     (exp_q.size() > 0) ? exp_q[0] : 35'h0);
                        else n_pass++;
                    end else if (out_valid) begin
                        n_total++;
                        if (exp_q.size() == 0) $display("FAIL b2b_unexpected: got %h expected no result", {exc, r});
                        else begin
                            expv = exp_q.pop_front();
                            if ({exc, r} !== expv) $display("FAIL b2b_order[%0d]: got %h expected %h", got_n, {exc, r}, expv);
                            else n_pass++;
                        end
                        got_n++;
                    end
                end
            end
        join
        out_ready = 1'b1;
        n_total++; if (got_n != 6) $display("FAIL b2b_count: got %0d expected 6", got_n); else n_pass++;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        n_total++; if (extra != 0) $display("FAIL b2b_duplicate: got %0d extra expected 0", extra); else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset_inflight();
        int stale;
        send(32'h3F800000, 32'h3F800000, 1'b0, {3'b000, 32'h40000000});
        send(32'h40000000, 32'h40000000, 1'b0, {3'b000, 32'h40800000});
        send(32'h40400000, 32'h3F800000, 1'b0, {3'b000, 32'h40800000});
        #1;
        reset = 1'b0;
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL inflight_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_total++; if ({exc, r} !== '0) $display("FAIL inflight_r_exc: got %h expected 0", {exc, r}); else n_pass++;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL inflight_in_ready: got %b expected 1", in_ready); else n_pass++;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        n_total++; if (stale != 0) $display("FAIL inflight_stale: got %0d results expected 0", stale); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_cancel();
        test_exceptions();
        test_rounding();
        test_back_to_back();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
